// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory port arbiter:
// FSM states, owner identities and access kinds.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    typedef enum logic [2:0] {
        KIND_FETCH   = 3'd0,
        KIND_LOAD_W  = 3'd1,
        KIND_LOAD_B  = 3'd2,
        KIND_STORE_W = 3'd3,
        KIND_STORE_B = 3'd4
    } kind_t;

    function automatic logic kind_is_byte(input kind_t k);
        return (k == KIND_LOAD_B) || (k == KIND_STORE_B);
    endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Replaces one byte lane of a word (store merge) and extracts that same lane
// (byte-load select); purely combinational.
module byte_lane_merge #(
    parameter int BYTE_SIZE = 4,
    parameter int LW        = 2
) (
    input  logic [BYTE_SIZE*8-1:0] word_in,
    input  logic [7:0]             byte_in,
    input  logic [LW-1:0]          lane,
    output logic [BYTE_SIZE*8-1:0] merged,
    output logic [7:0]             lane_byte
);

    logic [7:0] lanes [BYTE_SIZE];

    generate
        for (genvar gi = 0; gi < BYTE_SIZE; gi++) begin : g_lane
            assign lanes[gi]           = word_in[gi*8 +: 8];
            assign merged[gi*8 +: 8]   = (lane == LW'(gi)) ? byte_in : lanes[gi];
        end
    endgenerate

    assign lane_byte = lanes[lane];

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one word-wide single-port memory between the
// fetch unit and the load/store unit; byte stores are done as read-modify-write.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int BYTE_SIZE  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_BYTES  = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_req,
    input  logic [ADDR_WIDTH-1:0]     i_addr,
    output logic                      i_ack,
    output logic                      i_err,
    output logic [BYTE_SIZE*8-1:0]    i_rdata,
    input  logic                      d_req,
    input  logic                      d_we,
    input  logic                      d_byte,
    input  logic [ADDR_WIDTH-1:0]     d_addr,
    input  logic [BYTE_SIZE*8-1:0]    d_wdata,
    output logic                      d_ack,
    output logic                      d_err,
    output logic [BYTE_SIZE*8-1:0]    d_rdata,
    output logic [ADDR_WIDTH-1:0]     mem_ADDR,
    output logic                      mem_WE,
    output logic [BYTE_SIZE*8-1:0]    mem_WD,
    input  logic [BYTE_SIZE*8-1:0]    mem_RD
);

    localparam int DW = BYTE_SIZE * 8;
    localparam int AW = ADDR_WIDTH;
    localparam int LW = (BYTE_SIZE > 1) ? $clog2(BYTE_SIZE) : 1;

    state_t          state_reg, state_next;
    owner_t          owner_reg, owner_next, last_reg, owner_pick;
    kind_t           kind_reg, kind_next, sel_kind;
    logic            err_reg, err_next;
    logic            grant;
    logic [AW-1:0]   addr_reg;
    logic [LW-1:0]   lane_reg;
    logic [DW-1:0]   wdata_reg, word_reg, i_rdata_reg, d_rdata_reg;

    logic [AW-1:0]   sel_addr, sel_aligned;
    logic [AW:0]     sel_end;
    logic            sel_bad;
    logic [DW-1:0]   merge_word, merged;
    logic [7:0]      lane_byte;

    // Tie goes to whoever was not granted last.
    always_comb begin
        owner_pick = OWN_D;
        if (i_req && d_req) begin
            owner_pick = (last_reg == OWN_I) ? OWN_D : OWN_I;
        end else if (i_req) begin
            owner_pick = OWN_I;
        end
    end

    always_comb begin
        sel_kind = KIND_FETCH;
        sel_addr = i_addr;
        if (owner_pick == OWN_D) begin
            sel_addr = d_addr;
            if (d_we) sel_kind = d_byte ? KIND_STORE_B : KIND_STORE_W;
            else      sel_kind = d_byte ? KIND_LOAD_B  : KIND_LOAD_W;
        end
    end

    assign sel_aligned = {sel_addr[AW-1:LW], {LW{1'b0}}};
    assign sel_end     = {1'b0, sel_aligned} + (AW+1)'(BYTE_SIZE);
    assign sel_bad     = (!kind_is_byte(sel_kind) && (sel_addr[LW-1:0] != '0))
                       || (sel_end > (AW+1)'(MEM_BYTES));

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        kind_next  = kind_reg;
        err_next   = err_reg;
        grant      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    grant      = 1'b1;
                    owner_next = owner_pick;
                    kind_next  = sel_kind;
                    err_next   = sel_bad;
                    if (sel_bad)                       state_next = ST_RESP;
                    else if (sel_kind == KIND_STORE_W) state_next = ST_WRITE;
                    else                               state_next = ST_READ;
                end
            end
            ST_READ:  state_next = (kind_reg == KIND_STORE_B) ? ST_WRITE : ST_RESP;
            ST_WRITE: state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            owner_reg   <= OWN_I;
            last_reg    <= OWN_D;
            kind_reg    <= KIND_FETCH;
            err_reg     <= 1'b0;
            addr_reg    <= '0;
            lane_reg    <= '0;
            wdata_reg   <= '0;
            word_reg    <= '0;
            i_rdata_reg <= '0;
            d_rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            kind_reg  <= kind_next;
            err_reg   <= err_next;
            if (grant) begin
                last_reg <= owner_pick;
                // Rejected accesses leave the memory address untouched.
                if (!sel_bad) begin
                    addr_reg  <= sel_aligned;
                    lane_reg  <= sel_addr[LW-1:0];
                    wdata_reg <= d_wdata;
                end
            end
            if (state_reg == ST_READ) begin
                word_reg <= mem_RD;
                if (owner_reg == OWN_I) begin
                    i_rdata_reg <= mem_RD;
                end else if (kind_reg == KIND_LOAD_W) begin
                    d_rdata_reg <= mem_RD;
                end else if (kind_reg == KIND_LOAD_B) begin
                    d_rdata_reg <= {{(DW-8){1'b0}}, lane_byte};
                end
            end
        end
    end

    // Lane select reads the live memory word; the store merge uses the captured one.
    assign merge_word = (state_reg == ST_READ) ? mem_RD : word_reg;

    byte_lane_merge #(
        .BYTE_SIZE (BYTE_SIZE),
        .LW        (LW)
    ) u_merge (
        .word_in   (merge_word),
        .byte_in   (wdata_reg[7:0]),
        .lane      (lane_reg),
        .merged    (merged),
        .lane_byte (lane_byte)
    );

    assign i_ack    = (state_reg == ST_RESP) && (owner_reg == OWN_I);
    assign d_ack    = (state_reg == ST_RESP) && (owner_reg == OWN_D);
    assign i_err    = i_ack && err_reg;
    assign d_err    = d_ack && err_reg;
    assign i_rdata  = i_rdata_reg;
    assign d_rdata  = d_rdata_reg;
    assign mem_ADDR = addr_reg;
    assign mem_WE   = (state_reg == ST_WRITE);
    assign mem_WD   = (state_reg != ST_WRITE)      ? '0
                    : (kind_reg == KIND_STORE_B)   ? merged
                    :                                wdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a 256-byte memory model plus a
// reference byte array predicting every ack, error, read word and latency.
module tb_mem_port_arbiter;

    logic        clk, rst_n;
    logic        i_req, d_req, d_we, d_byte;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_ack, i_err, d_ack, d_err, mem_WE;
    logic [31:0] i_rdata, d_rdata, mem_ADDR, mem_WD, mem_RD;

    mem_port_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_ack    (i_ack),
        .i_err    (i_err),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_byte   (d_byte),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_err    (d_err),
        .d_rdata  (d_rdata),
        .mem_ADDR (mem_ADDR),
        .mem_WE   (mem_WE),
        .mem_WD   (mem_WD),
        .mem_RD   (mem_RD)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0] mem     [256];
    logic [7:0] exp_mem [256];
    int checks   = 0;
    int failures = 0;
    int we_count = 0;
    bit last_d;

    typedef struct {
        bit          port;
        bit          err;
        bit          has_rd;
        logic [31:0] rdata;
        int          lat;
    } exp_t;
    exp_t sb[$];

    function automatic logic [7:0] init_byte(input int k);
        case (k)
            32: return 8'h11;
            33: return 8'h22;
            34: return 8'h33;
            35: return 8'h44;
            default: return 8'((k * 37 + 5) & 255);
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory model: combinational read, write on posedge using inputs sampled mid-cycle.
    logic [7:0]  ra, ra1, ra2, ra3;
    logic        s_we;
    logic [31:0] s_a, s_wd;
    assign ra  = mem_ADDR[7:0];
    assign ra1 = ra + 8'd1;
    assign ra2 = ra + 8'd2;
    assign ra3 = ra + 8'd3;
    assign mem_RD = {mem[ra3], mem[ra2], mem[ra1], mem[ra]};

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = init_byte(k);
        forever begin
            @(negedge clk);
            s_we = mem_WE;
            s_a  = mem_ADDR;
            s_wd = mem_WD;
            @(posedge clk);
            if (s_we) begin
                we_count++;
                check("we_range", {8'h0, s_a[31:8]}, 0);
                for (int j = 0; j < 4; j++) mem[8'(s_a[7:0] + 8'(j))] = s_wd[8*j +: 8];
            end
        end
    end

    function automatic bit model_err(input logic [31:0] a, input bit byt);
        logic [32:0] e;
        e = {1'b0, a[31:2], 2'b00} + 33'd4;
        return (!byt && (a[1:0] != 2'b00)) || (e > 33'd256);
    endfunction

    function automatic int model_lat(input logic [31:0] a, input bit we, input bit byt);
        if (model_err(a, byt)) return 1;
        if (we && byt) return 3;
        return 2;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        logic [7:0] b;
        b = {a[7:2], 2'b00};
        return {exp_mem[8'(b + 8'd3)], exp_mem[8'(b + 8'd2)], exp_mem[8'(b + 8'd1)], exp_mem[b]};
    endfunction

    task automatic push(input bit port, input logic [31:0] a, input bit we, input bit byt,
                        input logic [31:0] wd, input int off);
        exp_t e;
        e.port   = port;
        e.err    = model_err(a, byt);
        e.lat    = off + model_lat(a, we, byt);
        e.has_rd = !we && !e.err;
        e.rdata  = 32'h0;
        if (!e.err) begin
            if (!we) begin
                e.rdata = byt ? {24'h0, exp_mem[a[7:0]]} : exp_word(a);
            end else if (byt) begin
                exp_mem[a[7:0]] = wd[7:0];
            end else begin
                for (int j = 0; j < 4; j++) exp_mem[{a[7:2], 2'(j)}] = wd[8*j +: 8];
            end
        end
        sb.push_back(e);
        last_d = port;
    endtask

    task automatic wait_all(input int budget);
        int n;
        exp_t e;
        bit p;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (i_ack || d_ack) begin
                if (i_ack && d_ack) check("dual_ack", 1, 0);
                p = d_ack;
                e = sb.pop_front();
                check("ack_port", 64'(p), 64'(e.port));
                check("ack_lat", 64'(n), 64'(e.lat));
                check("ack_err", 64'(p ? d_err : i_err), 64'(e.err));
                if (e.has_rd) check("rdata", p ? d_rdata : i_rdata, e.rdata);
                $display("txn port=%s err=%0b rdata=%08h lat=%0d", p ? "D" : "I",
                         p ? d_err : i_err, p ? d_rdata : i_rdata, n);
                if (i_ack) i_req = 1'b0;
                if (d_ack) d_req = 1'b0;
            end
        end
        if (sb.size() != 0) begin
            check("ack_timeout", 64'(sb.size()), 0);
            sb.delete();
        end
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_d(input logic [31:0] a, input bit we, input bit byt, input logic [31:0] wd);
        d_addr = a; d_we = we; d_byte = byt; d_wdata = wd; d_req = 1'b1;
    endtask

    task automatic fetch(input logic [31:0] a);
        go_idle();
        i_addr = a; i_req = 1'b1;
        push(1'b0, a, 1'b0, 1'b0, 32'h0, 0);
        wait_all(20);
    endtask

    task automatic data(input logic [31:0] a, input bit we, input bit byt, input logic [31:0] wd);
        go_idle();
        drive_d(a, we, byt, wd);
        push(1'b1, a, we, byt, wd, 0);
        wait_all(20);
    endtask

    task automatic tie(input logic [31:0] ia, input logic [31:0] da, input bit we, input bit byt,
                       input logic [31:0] wd);
        bit data_first;
        go_idle();
        data_first = !last_d;
        i_addr = ia; i_req = 1'b1;
        drive_d(da, we, byt, wd);
        if (data_first) begin
            push(1'b1, da, we, byt, wd, 0);
            push(1'b0, ia, 1'b0, 1'b0, 32'h0, model_lat(da, we, byt) + 1);
        end else begin
            push(1'b0, ia, 1'b0, 1'b0, 32'h0, 0);
            push(1'b1, da, we, byt, wd, model_lat(ia, 1'b0, 1'b0) + 1);
        end
        wait_all(30);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_i_ack"},   64'(i_ack),   0);
        check({tag, "_d_ack"},   64'(d_ack),   0);
        check({tag, "_i_err"},   64'(i_err),   0);
        check({tag, "_d_err"},   64'(d_err),   0);
        check({tag, "_mem_WE"},  64'(mem_WE),  0);
        check({tag, "_i_rdata"}, 64'(i_rdata), 0);
        check({tag, "_d_rdata"}, 64'(d_rdata), 0);
        check({tag, "_mem_ADDR"}, 64'(mem_ADDR), 0);
        check({tag, "_mem_WD"},  64'(mem_WD),  0);
    endtask

    int we0;

    initial begin
        rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_byte = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
        last_d = 1'b1;
        for (int k = 0; k < 256; k++) exp_mem[k] = init_byte(k);

        // Reset state, then idle without requests
        #2;
        check_outputs_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        we0 = we_count;
        repeat (5) begin
            @(negedge clk);
            check("idle_ack", {62'h0, i_ack, d_ack}, 0);
        end
        check("idle_we", 64'(we_count - we0), 0);

        // Ties alternate by round-robin; a solo fetch in between moves the pointer
        tie(32'h00, 32'h10, 1'b0, 1'b0, 32'h0);
        fetch(32'h40);
        tie(32'h04, 32'h14, 1'b0, 1'b0, 32'h0);

        // Byte store read-modify-write
        we0 = we_count;
        data(32'h21, 1'b1, 1'b1, 32'h0000_00AB);
        check("bst_we_pulses", 64'(we_count - we0), 1);
        check("bst_mem", {mem[35], mem[34], mem[33], mem[32]}, 32'h4433AB11);

        // Misaligned word load is rejected without touching memory
        we0 = we_count;
        data(32'h02, 1'b0, 1'b0, 32'h0);
        check("misalign_we", 64'(we_count - we0), 0);

        // Word store then read back
        we0 = we_count;
        data(32'h30, 1'b1, 1'b0, 32'hDEADBEEF);
        check("wst_we_pulses", 64'(we_count - we0), 1);
        check("wst_mem", {mem[51], mem[50], mem[49], mem[48]}, exp_word(32'h30));
        data(32'h30, 1'b0, 1'b0, 32'h0);
        data(32'h33, 1'b0, 1'b1, 32'h0);

        // Top-of-memory boundaries
        fetch(32'hFC);
        fetch(32'h100);
        data(32'hFF, 1'b0, 1'b1, 32'h0);

        // Reset during the read phase of a byte store
        go_idle();
        drive_d(32'h25, 1'b1, 1'b1, 32'h0000_0077);
        we0 = we_count;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_d = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("postrst_ack", {62'h0, i_ack, d_ack}, 0);
        end
        check("postrst_we", 64'(we_count - we0), 0);
        check("postrst_mem", {mem[39], mem[38], mem[37], mem[36]}, exp_word(32'h24));

        // Round-robin pointer is back to fetch-first after reset
        tie(32'h08, 32'h18, 1'b0, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
